led_seq_ctrl: RTL and testbench
===============================

Name: led_seq_ctrl

Overview:
Controller that sequences the 3-bit LED colour through the 001..110 cycle from a raw push-button.
- Synchronises and debounces the button.
- Advances once on press, then auto-repeats at a fixed rate while the button is held; holds colour on release.
- Sits between the board button pin and the LED driver; replaces edge-clocked button logic with a fully single-clock design.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable cycles of synchronised button required to accept a level change (>=1)
STEP_CYCLES, 8, cycles between auto-advances while held (>=2)
CNT_W, 16, width of internal debounce/step counters (must hold max(DEBOUNCE_CYCLES, STEP_CYCLES))

Ports:
clk  input  1  system clock, all logic on posedge
rst_n  input  1  synchronous, active-low reset
button  input  1  raw asynchronous push-button level
enable  input  1  0 = freeze sequencing
colour  output  3  current LED colour, registered
step  output  1  one-cycle pulse, high in the first cycle a new colour is visible
btn_stable  output  1  debounced button level, registered

Behaviour:
- Interface: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset (rst_n=0 at posedge): colour=001, step=0, btn_stable=0, FSM=IDLE, all counters 0, direction=up. Reset mid-hold aborts immediately.
- Synchroniser: 2-flop on button gives btn_sync, 2 cycles latency.
- Debounce:
  - Counter increments while btn_sync != btn_stable; clears on any cycle they are equal.
  - When the count reaches DEBOUNCE_CYCLES, btn_stable toggles and the counter clears.
  - Clean edge sampled at edge N gives btn_stable change visible at edge N+2+DEBOUNCE_CYCLES.
- FSM states:
  - IDLE: btn_stable=0, step timer cleared.
  - PRESS: entered on btn_stable rising with enable=1. At the next edge colour advances, step=1; go to HOLD, timer=0.
  - HOLD: timer counts each cycle. When timer==STEP_CYCLES-1: advance colour, step=1, timer=0.
  - Any state with btn_stable=0 goes to IDLE next edge, with no advance on that edge.
- Sequence: 001→010→011→100→101→110→001 (wrap).
- Illegal colour (000/111, e.g. after SEU) is forced to 001 at the next edge. step=0 for that correction; the sequence resumes from 001.
- enable=0:
  - colour holds, step=0, timer cleared, FSM forced to IDLE; the debouncer keeps running.
  - If enable rises while btn_stable=1: enter HOLD with timer=0 and no immediate advance; first advance comes after STEP_CYCLES cycles.
- Simultaneous btn_stable fall and timer expiry: release wins, no advance.
- step never high in two consecutive cycles (STEP_CYCLES>=2).

Optional Feature:
Macro LED_SEQ_PINGPONG_EN.
- Defined: an internal direction bit (reset=up) makes the sequence bounce: 001↑…110, then 101↓…001, then 010↑. Illegal-value correction also sets direction=up.
- Undefined: direction logic is absent; wrap 110→001 as above.

Decomposition:
Package led_pkg holds:
- colour_t (logic [2:0]);
- constants COLOUR_FIRST=3'b001 and COLOUR_LAST=3'b110;
- FSM state enum (IDLE, PRESS, HOLD);
- function next_colour(colour_t c, logic dir).

One sub-module, btn_debounce, contains the synchroniser and debounce counter with parameters DEBOUNCE_CYCLES and CNT_W. It outputs btn_stable.

Test Plan:
(Defaults DEBOUNCE_CYCLES=4, STEP_CYCLES=8, enable=1 unless stated.)
- Reset then clean press at edge 10, held → btn_stable=1 at edge 16; colour 001→010 with step=1 at edge 17. Further advances at 25, 33, 41, 49 (011, 100, 101, 110); 001 at 57.
- Button glitch high for 3 cycles → btn_stable stays 0, colour unchanged, step never asserted.
- Press, release after first advance → colour holds at 010 indefinitely; a second press gives exactly one advance to 011.
- Hold with enable=0 from edge 20 to 40 → colour frozen, no step. enable rise at 40 → next advance at edge 48.
- rst_n=0 for one edge during HOLD with colour=101 → colour=001, step=0 next cycle. Button still held after reset: a fresh debounce is required before the next advance.
- LED_SEQ_PINGPONG_EN defined, hold 12 advances from 001 → 010,011,100,101,110,101,100,011,010,001,010,011.

Source files
------------

// File: rtl/led_seq_ctrl_pkg.sv
// Shared types, colour constants and the colour-step function for the LED sequencer.
// LED_SEQ_PINGPONG_EN selects bounce (ping-pong) stepping instead of wrap-around.
package led_pkg;

  typedef logic [2:0] colour_t;

  localparam colour_t COLOUR_FIRST = 3'b001;
  localparam colour_t COLOUR_LAST  = 3'b110;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    HOLD  = 2'd2
  } state_e;

  function automatic logic colour_legal(colour_t c);
    return (c != 3'b000) && (c != 3'b111);
  endfunction

  // Ping-pong turns around at either end; otherwise the sequence wraps in the given direction.
  function automatic colour_t next_colour(colour_t c, logic dir);
    colour_t n;
`ifdef LED_SEQ_PINGPONG_EN
    if (dir == DIR_UP) n = (c == COLOUR_LAST)  ? c - 3'd1 : c + 3'd1;
    else               n = (c == COLOUR_FIRST) ? c + 3'd1 : c - 3'd1;
`else
    if (dir == DIR_UP) n = (c == COLOUR_LAST)  ? COLOUR_FIRST : c + 3'd1;
    else               n = (c == COLOUR_FIRST) ? COLOUR_LAST  : c - 3'd1;
`endif
    return n;
  endfunction

endpackage

// File: rtl/led_seq_ctrl_btn_debounce.sv
// Two-flop synchroniser plus stability counter for the raw push-button.
// Also exposes which edge the debounced level is about to take, so the caller can react on that edge.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic button,
  output logic btn_stable,
  output logic stable_rise,
  output logic stable_fall
);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             toggle;

  // The counter must reach DEBOUNCE_CYCLES and still see a mismatch before the level flips.
  always_comb begin
    cnt_d  = '0;
    toggle = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES)) toggle = 1'b1;
      else                                  cnt_d  = cnt_q + CNT_W'(1);
    end
    stable_d = stable_q ^ toggle;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= button;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign btn_stable  = stable_q;
  assign stable_rise = toggle & ~stable_q;
  assign stable_fall = toggle &  stable_q;

endmodule

// File: rtl/led_seq_ctrl.sv
// Push-button driven LED colour sequencer: one advance per press, auto-repeat while held.
// Optional macro LED_SEQ_PINGPONG_EN makes the sequence bounce between 001 and 110.
module led_seq_ctrl
  import led_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int STEP_CYCLES     = 8,
  parameter int CNT_W           = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       button,
  input  logic       enable,
  output logic [2:0] colour,
  output logic       step,
  output logic       btn_stable
);

  state_e           state_q, state_d;
  colour_t          colour_q, colour_d;
  logic             step_q, step_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             stable_rise, stable_fall;
  logic             released;
  logic             advance;
  logic             dir_cur;

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_debounce (
    .clk         (clk),
    .rst_n       (rst_n),
    .button      (button),
    .btn_stable  (btn_stable),
    .stable_rise (stable_rise),
    .stable_fall (stable_fall)
  );

  // A fall landing on this edge counts as released, so it beats a coincident timer expiry.
  assign released = ~btn_stable | stable_fall;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    advance = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      timer_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          timer_d = '0;
          if (stable_rise)              state_d = PRESS;
          else if (!released)           state_d = HOLD;
        end
        PRESS: begin
          timer_d = '0;
          if (released) state_d = IDLE;
          else begin
            advance = 1'b1;
            state_d = HOLD;
          end
        end
        HOLD: begin
          if (released) begin
            state_d = IDLE;
            timer_d = '0;
          end else if (timer_q == CNT_W'(STEP_CYCLES - 1)) begin
            advance = 1'b1;
            timer_d = '0;
          end else begin
            timer_d = timer_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          timer_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    colour_d = colour_q;
    step_d   = 1'b0;
    if (!colour_legal(colour_q)) begin
      colour_d = COLOUR_FIRST;
    end else if (advance) begin
      colour_d = next_colour(colour_q, dir_cur);
      step_d   = 1'b1;
    end
  end

`ifdef LED_SEQ_PINGPONG_EN
  logic dir_q, dir_d;

  always_comb begin
    dir_d = dir_q;
    if (!colour_legal(colour_q)) begin
      dir_d = DIR_UP;
    end else if (advance) begin
      if (dir_q == DIR_UP && colour_q == COLOUR_LAST)         dir_d = DIR_DOWN;
      else if (dir_q == DIR_DOWN && colour_q == COLOUR_FIRST) dir_d = DIR_UP;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) dir_q <= DIR_UP;
    else        dir_q <= dir_d;
  end

  assign dir_cur = dir_q;
`else
  assign dir_cur = DIR_UP;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      colour_q <= COLOUR_FIRST;
      step_q   <= 1'b0;
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      colour_q <= colour_d;
      step_q   <= step_d;
      timer_q  <= timer_d;
    end
  end

  assign colour = colour_q;
  assign step   = step_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Directed bench for led_seq_ctrl: press/repeat timing, glitch rejection, release, enable and reset.
// Edge numbers are counted from the reset edge (edge 0); inputs change just after an edge.
module tb_led_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       button;
  logic       enable;
  logic [2:0] colour;
  logic       step;
  logic       btn_stable;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_n   = 0;

  always #5 clk = ~clk;

  led_seq_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .button     (button),
    .enable     (enable),
    .colour     (colour),
    .step       (step),
    .btn_stable (btn_stable)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", tag, edge_n, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic run_to(input int n);
    while (edge_n < n) tick();
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    button = 1'b0;
    enable = 1'b1;
    tick();
    rst_n  = 1'b1;
    edge_n = 0;
  endtask

  logic [2:0] exp_seq [12];
  logic [2:0] prev;
  int         e;

  initial begin
`ifdef LED_SEQ_PINGPONG_EN
    exp_seq = '{3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b101,
                3'b100, 3'b011, 3'b010, 3'b001, 3'b010, 3'b011};
`else
    exp_seq = '{3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b001,
                3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b001};
`endif

    // Reset state and held-button auto-repeat sequence
    do_reset();
    chk("rst_colour", colour, 3'b001);
    chk("rst_step", step, 1'b0);
    chk("rst_stable", btn_stable, 1'b0);
    run_to(9);
    button = 1'b1;
    run_to(15);
    chk("press_stable_early", btn_stable, 1'b0);
    run_to(16);
    chk("press_stable", btn_stable, 1'b1);
    chk("press_no_adv_yet", colour, 3'b001);
    prev = 3'b001;
    for (int k = 0; k < 12; k++) begin
      e = 17 + 8 * k;
      run_to(e - 1);
      chk("hold_pre_step", step, 1'b0);
      chk("hold_pre_colour", colour, prev);
      run_to(e);
      chk("hold_colour", colour, exp_seq[k]);
      chk("hold_step", step, 1'b1);
      prev = exp_seq[k];
    end
    $display("seq: 12 held advances checked, last colour %03b", colour);

    // Short glitches (3 and 4 cycles) must be rejected
    for (int w = 3; w <= 4; w++) begin
      do_reset();
      run_to(9);
      button = 1'b1;
      run_to(9 + w);
      button = 1'b0;
      for (int t = 10; t <= 30; t++) begin
        run_to(t);
        chk("glitch_stable", btn_stable, 1'b0);
        chk("glitch_step", step, 1'b0);
      end
      chk("glitch_colour", colour, 3'b001);
      $display("glitch: width %0d cycles, colour %03b", w, colour);
    end

    // Release after first advance; release fall coincides with timer expiry
    do_reset();
    run_to(9);
    button = 1'b1;
    run_to(17);
    chk("rel_first_colour", colour, 3'b010);
    chk("rel_first_step", step, 1'b1);
    run_to(18);
    button = 1'b0;
    run_to(24);
    chk("rel_stable_still", btn_stable, 1'b1);
    run_to(25);
    chk("rel_stable_fall", btn_stable, 1'b0);
    chk("rel_wins_colour", colour, 3'b010);
    chk("rel_wins_step", step, 1'b0);
    for (int t = 26; t <= 60; t++) begin
      run_to(t);
      chk("rel_idle_step", step, 1'b0);
    end
    chk("rel_hold_colour", colour, 3'b010);
    button = 1'b1;
    run_to(67);
    chk("repress_stable", btn_stable, 1'b1);
    chk("repress_pre_colour", colour, 3'b010);
    run_to(68);
    chk("repress_colour", colour, 3'b011);
    chk("repress_step", step, 1'b1);
    run_to(69);
    button = 1'b0;
    for (int t = 70; t <= 100; t++) begin
      run_to(t);
      chk("repress_single_step", step, 1'b0);
    end
    chk("repress_final_colour", colour, 3'b011);
    $display("release: colour held at %03b after one re-press advance", colour);

    // enable low from edge 20 to 39 freezes sequencing; re-enable restarts the step timer
    do_reset();
    run_to(9);
    button = 1'b1;
    run_to(17);
    chk("en_first_colour", colour, 3'b010);
    run_to(19);
    enable = 1'b0;
    for (int t = 20; t <= 39; t++) begin
      run_to(t);
      chk("en_frozen_step", step, 1'b0);
      chk("en_frozen_colour", colour, 3'b010);
    end
    enable = 1'b1;
    run_to(40);
    chk("en_rise_no_adv", step, 1'b0);
    run_to(47);
    chk("en_pre_colour", colour, 3'b010);
    chk("en_pre_step", step, 1'b0);
    run_to(48);
    chk("en_adv_colour", colour, 3'b011);
    chk("en_adv_step", step, 1'b1);
    $display("enable: first advance after re-enable at edge %0d, colour %03b", edge_n, colour);

    // Reset during HOLD at colour 101, button kept held
    do_reset();
    run_to(9);
    button = 1'b1;
    run_to(41);
    chk("mid_colour_101", colour, 3'b101);
    chk("mid_step", step, 1'b1);
    rst_n = 1'b0;
    run_to(42);
    rst_n = 1'b1;
    chk("mid_rst_colour", colour, 3'b001);
    chk("mid_rst_step", step, 1'b0);
    chk("mid_rst_stable", btn_stable, 1'b0);
    for (int t = 43; t <= 48; t++) begin
      run_to(t);
      chk("mid_redebounce", btn_stable, 1'b0);
      chk("mid_no_step", step, 1'b0);
    end
    run_to(49);
    chk("mid_stable_again", btn_stable, 1'b1);
    chk("mid_colour_hold", colour, 3'b001);
    run_to(50);
    chk("mid_adv_colour", colour, 3'b010);
    chk("mid_adv_step", step, 1'b1);
    $display("reset-in-hold: re-debounced advance at edge %0d, colour %03b", edge_n, colour);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
